// File: rtl/dram_arbiter.sv
// Two-master round-robin arbiter for the single data-RAM port.
// One transfer per grant; registered command toward the DRAM, read data returned after RD_LAT cycles.
module dram_arbiter #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int RD_LAT = 0
) (
   input  logic              cpu_clk,
   input  logic              cpu_rst,

   input  logic              m0_req,
   input  logic              m0_we,
   input  logic [ADDR_W-1:0] m0_addr,
   input  logic [DATA_W-1:0] m0_wdata,
   output logic              m0_ack,
   output logic [DATA_W-1:0] m0_rdata,

   input  logic              m1_req,
   input  logic              m1_we,
   input  logic [ADDR_W-1:0] m1_addr,
   input  logic [DATA_W-1:0] m1_wdata,
   output logic              m1_ack,
   output logic [DATA_W-1:0] m1_rdata,

   output logic [ADDR_W-1:0] dram_addr,
   output logic              dram_we,
   output logic [DATA_W-1:0] dram_wdata,
   input  logic [DATA_W-1:0] dram_rdata,

   output logic              busy,
   output logic              gnt_id
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      XFER   = 2'd1,
      RDWAIT = 2'd2
   } state_t;

   localparam logic [1:0] CNT_LOAD = (RD_LAT > 0) ? 2'(RD_LAT - 1) : 2'd0;

   state_t            state_q, state_d;
   logic              last_gnt_q, last_gnt_d;
   logic              gnt_id_q, gnt_id_d;
   logic              we_q, we_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [1:0]        cnt_q, cnt_d;

   logic              pick;
   logic              done;

   always_ff @(posedge cpu_clk or posedge cpu_rst) begin
      if (cpu_rst) begin
         state_q    <= IDLE;
         last_gnt_q <= 1'b1;
         gnt_id_q   <= 1'b0;
         we_q       <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         cnt_q      <= '0;
      end else begin
         state_q    <= state_d;
         last_gnt_q <= last_gnt_d;
         gnt_id_q   <= gnt_id_d;
         we_q       <= we_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         cnt_q      <= cnt_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      last_gnt_d = last_gnt_q;
      gnt_id_d   = gnt_id_q;
      we_d       = we_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      cnt_d      = cnt_q;
      done       = 1'b0;

      // Master 1 wins when it is the only requester, or on a tie when master 0 went last.
      pick = m1_req & (~m0_req | ~last_gnt_q);

      case (state_q)
         IDLE: begin
            if (m0_req | m1_req) begin
               addr_d     = pick ? m1_addr  : m0_addr;
               wdata_d    = pick ? m1_wdata : m0_wdata;
               we_d       = pick ? m1_we    : m0_we;
               gnt_id_d   = pick;
               last_gnt_d = pick;
               state_d    = XFER;
            end
         end
         XFER: begin
            if (we_q || (RD_LAT == 0)) begin
               done    = 1'b1;
               state_d = IDLE;
            end else begin
               cnt_d   = CNT_LOAD;
               state_d = RDWAIT;
            end
         end
         RDWAIT: begin
            if (cnt_q != 2'd0) begin
               cnt_d = cnt_q - 2'd1;
            end else begin
               done    = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign dram_addr  = addr_q;
   assign dram_wdata = wdata_q;
   assign dram_we    = (state_q == XFER) && we_q;
   assign busy       = (state_q != IDLE);
   assign gnt_id     = gnt_id_q;

   assign m0_ack   = done & ~gnt_id_q;
   assign m1_ack   = done &  gnt_id_q;
   assign m0_rdata = (m0_ack && !we_q) ? dram_rdata : '0;
   assign m1_rdata = (m1_ack && !we_q) ? dram_rdata : '0;

   rd_lat_legal: assert property (@(posedge cpu_clk) (RD_LAT >= 0) && (RD_LAT <= 3))
      else $error("dram_arbiter: RD_LAT=%0d outside 0..3", RD_LAT);

   ack_onehot: assert property (@(posedge cpu_clk) disable iff (cpu_rst) !(m0_ack && m1_ack))
      else $error("dram_arbiter: both acks asserted");

endmodule

// File: tb/tb_dram_arbiter.sv
// Bench for dram_arbiter: three instances (RD_LAT 0, 2, 3) checked every cycle
// against a transaction-window model, with directed steps followed by random traffic.
module tb_dram_arbiter;
   localparam int NI = 3;

   logic cpu_clk = 1'b0;
   logic cpu_rst = 1'b0;
   always #5 cpu_clk = ~cpu_clk;

   logic        mreq   [NI][2];
   logic        mwe    [NI][2];
   logic [31:0] maddr  [NI][2];
   logic [31:0] mwdata [NI][2];

   logic        m0_ack [NI], m1_ack [NI], dram_we [NI], busy [NI], gnt_id [NI];
   logic [31:0] m0_rdata [NI], m1_rdata [NI];
   logic [31:0] dram_addr [NI], dram_wdata [NI], dram_rdata [NI];

   function automatic int lat_of(input int k);
      return (k == 0) ? 0 : k + 1;
   endfunction

   function automatic logic [31:0] dram_fn(input logic [31:0] a);
      if (a == 32'h0000_0020) return 32'h1234_5678;
      return {a[15:0], ~a[15:0]} ^ 32'h5A5A_0F0F;
   endfunction

   for (genvar g = 0; g < NI; g++) begin : g_inst
      logic [31:0] d1, d2, d3;
      always @(posedge cpu_clk) begin
         d1 <= dram_addr[g];
         d2 <= d1;
         d3 <= d2;
      end
      // DRAM returns the word for the address presented RD_LAT cycles earlier.
      assign dram_rdata[g] = dram_fn((g == 0) ? dram_addr[g] : (g == 1) ? d2 : d3);

      dram_arbiter #(
         .ADDR_W(32),
         .DATA_W(32),
         .RD_LAT((g == 0) ? 0 : g + 1)
      ) u_dut (
         .cpu_clk    (cpu_clk),
         .cpu_rst    (cpu_rst),
         .m0_req     (mreq[g][0]),
         .m0_we      (mwe[g][0]),
         .m0_addr    (maddr[g][0]),
         .m0_wdata   (mwdata[g][0]),
         .m0_ack     (m0_ack[g]),
         .m0_rdata   (m0_rdata[g]),
         .m1_req     (mreq[g][1]),
         .m1_we      (mwe[g][1]),
         .m1_addr    (maddr[g][1]),
         .m1_wdata   (mwdata[g][1]),
         .m1_ack     (m1_ack[g]),
         .m1_rdata   (m1_rdata[g]),
         .dram_addr  (dram_addr[g]),
         .dram_we    (dram_we[g]),
         .dram_wdata (dram_wdata[g]),
         .dram_rdata (dram_rdata[g]),
         .busy       (busy[g]),
         .gnt_id     (gnt_id[g])
      );
   end

   // Reference model: each transfer occupies cycles xfer_c..ack_c; the arbiter is free otherwise.
   int          cyc = 0;
   int          xfer_c [NI], ack_c [NI], gm [NI];
   logic        lat_we [NI], last [NI], gid [NI];
   logic [31:0] lat_addr [NI], lat_wdata [NI];
   logic        ack_e [NI][2];
   int          mode = 0;

   int nchk = 0;
   int npass = 0;

   task automatic check(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
      nchk++;
      assert (obs === exp) npass++;
      else $error("FAIL %s inst%0d cyc=%0d observed=%h expected=%h", tag, k, cyc, obs, exp);
   endtask

   function automatic logic mbusy(input int k, input int c);
      return (xfer_c[k] <= c) && (c <= ack_c[k]);
   endfunction

   task automatic model_reset();
      for (int k = 0; k < NI; k++) begin
         xfer_c[k] = 0;  ack_c[k] = -1;  gm[k] = 0;
         lat_we[k] = 1'b0;  lat_addr[k] = '0;  lat_wdata[k] = '0;
         last[k] = 1'b1;  gid[k] = 1'b0;
         ack_e[k][0] = 1'b0;  ack_e[k][1] = 1'b0;
      end
   endtask

   task automatic model_edge();
      for (int k = 0; k < NI; k++) begin
         int pick;
         pick = -1;
         if (!cpu_rst && !mbusy(k, cyc)) begin
            if (mreq[k][0] && mreq[k][1]) pick = last[k] ? 0 : 1;
            else if (mreq[k][0])          pick = 0;
            else if (mreq[k][1])          pick = 1;
         end
         if (pick >= 0) begin
            gm[k]        = pick;
            last[k]      = (pick == 1);
            gid[k]       = (pick == 1);
            lat_we[k]    = mwe[k][pick];
            lat_addr[k]  = maddr[k][pick];
            lat_wdata[k] = mwdata[k][pick];
            xfer_c[k]    = cyc + 1;
            ack_c[k]     = cyc + 1 + (mwe[k][pick] ? 0 : lat_of(k));
         end
      end
      cyc++;
   endtask

   task automatic check_all();
      for (int k = 0; k < NI; k++) begin
         logic b, a;
         b = mbusy(k, cyc);
         a = b && (cyc == ack_c[k]);
         ack_e[k][0] = a && (gm[k] == 0);
         ack_e[k][1] = a && (gm[k] == 1);
         check("busy",       k, busy[k],       b);
         check("dram_we",    k, dram_we[k],    b && (cyc == xfer_c[k]) && lat_we[k]);
         check("m0_ack",     k, m0_ack[k],     ack_e[k][0]);
         check("m1_ack",     k, m1_ack[k],     ack_e[k][1]);
         check("m0_rdata",   k, m0_rdata[k],   (ack_e[k][0] && !lat_we[k]) ? dram_fn(lat_addr[k]) : 32'h0);
         check("m1_rdata",   k, m1_rdata[k],   (ack_e[k][1] && !lat_we[k]) ? dram_fn(lat_addr[k]) : 32'h0);
         check("dram_addr",  k, dram_addr[k],  lat_addr[k]);
         check("dram_wdata", k, dram_wdata[k], lat_wdata[k]);
         check("gnt_id",     k, gnt_id[k],     gid[k]);
      end
   endtask

   task automatic new_cmd(input int k, input int m);
      mreq[k][m]   = 1'b1;
      mwe[k][m]    = ($urandom_range(1) == 1);
      maddr[k][m]  = ($urandom_range(7) == 0) ? 32'h20 : $urandom;
      mwdata[k][m] = $urandom;
   endtask

   task automatic drive();
      for (int k = 0; k < NI; k++) begin
         for (int m = 0; m < 2; m++) begin
            if (ack_e[k][m]) begin
               if (mode == 0) mreq[k][m] = 1'b0;
               else if (mode == 2) begin
                  if ($urandom_range(1) == 1) new_cmd(k, m);
                  else mreq[k][m] = 1'b0;
               end
            end else if (mode == 2) begin
               if (!mreq[k][m]) begin
                  if ($urandom_range(2) == 0) new_cmd(k, m);
               end else if (mbusy(k, cyc) && gm[k] == m && $urandom_range(3) == 0) begin
                  maddr[k][m]  = $urandom;
                  mwdata[k][m] = $urandom;
                  mwe[k][m]    = ($urandom_range(1) == 1);
               end
            end
         end
      end
   endtask

   task automatic tick();
      @(posedge cpu_clk);
      model_edge();
      @(negedge cpu_clk);
      check_all();
      drive();
   endtask

   task automatic clear_reqs();
      for (int k = 0; k < NI; k++)
         for (int m = 0; m < 2; m++) begin
            mreq[k][m] = 1'b0;  mwe[k][m] = 1'b0;
            maddr[k][m] = '0;   mwdata[k][m] = '0;
         end
   endtask

   task automatic apply_reset(input int n);
      cpu_rst = 1'b1;
      clear_reqs();
      model_reset();
      #1;
      check_all();
      repeat (n) begin
         @(posedge cpu_clk);
         model_edge();
         @(negedge cpu_clk);
         check_all();
      end
      cpu_rst = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int nack [NI];
      logic [3:0] ord [NI];
      logic [31:0] rd_val;

      clear_reqs();
      model_reset();
      #1;
      apply_reset(2);

      // Reset then idle.
      mode = 0;
      repeat (10) tick();

      // Single write from master 0 on every instance.
      for (int k = 0; k < NI; k++) begin
         mreq[k][0] = 1'b1;  mwe[k][0] = 1'b1;
         maddr[k][0] = 32'h10;  mwdata[k][0] = 32'hDEAD_BEEF;
      end
      tick();
      for (int k = 0; k < NI; k++) begin
         check("wr_ack_t1",  k, m0_ack[k],     1'b1);
         check("wr_we_t1",   k, dram_we[k],    1'b1);
         check("wr_addr_t1", k, dram_addr[k],  32'h10);
         check("wr_data_t1", k, dram_wdata[k], 32'hDEAD_BEEF);
      end
      tick();
      for (int k = 0; k < NI; k++) check("wr_busy_t2", k, busy[k], 1'b0);

      // Read with RD_LAT=2 from master 1.
      mreq[1][1] = 1'b1;  mwe[1][1] = 1'b0;  maddr[1][1] = 32'h20;
      n = 99;
      rd_val = '0;
      for (int i = 1; i <= 8; i++) begin
         tick();
         if (m1_ack[1] === 1'b1) begin
            n = i;
            rd_val = m1_rdata[1];
            break;
         end
      end
      check("rd_lat2_ack_cycle", 1, n, 3);
      check("rd_lat2_rdata", 1, rd_val, 32'h1234_5678);
      tick();

      // Contention: both masters hold writes from reset.
      apply_reset(1);
      mode = 1;
      for (int k = 0; k < NI; k++) begin
         nack[k] = 0;  ord[k] = '0;
         for (int m = 0; m < 2; m++) begin
            mreq[k][m] = 1'b1;  mwe[k][m] = 1'b1;
            maddr[k][m] = 32'h100 + m;  mwdata[k][m] = 32'hA000_0000 + m;
         end
      end
      repeat (8) begin
         tick();
         for (int k = 0; k < NI; k++) begin
            if (m0_ack[k] === 1'b1 && nack[k] < 4) begin ord[k][nack[k]] = 1'b0; nack[k]++; end
            if (m1_ack[k] === 1'b1 && nack[k] < 4) begin ord[k][nack[k]] = 1'b1; nack[k]++; end
         end
      end
      for (int k = 0; k < NI; k++) begin
         check("contend_count", k, nack[k], 4);
         check("contend_order", k, ord[k], 4'b1010);
      end
      mode = 0;
      clear_reqs();
      repeat (2) tick();

      // RD_LAT=3 read, command changed and request dropped during RDWAIT.
      mreq[2][0] = 1'b1;  mwe[2][0] = 1'b0;  maddr[2][0] = 32'h40;
      tick();
      tick();
      maddr[2][0] = 32'h99;  mreq[2][0] = 1'b0;
      tick();
      check("mid_addr_held", 2, dram_addr[2], 32'h40);
      check("mid_no_early_ack", 2, m0_ack[2], 1'b0);
      tick();
      check("mid_ack_t4", 2, m0_ack[2], 1'b1);
      check("mid_rdata_t4", 2, m0_rdata[2], dram_fn(32'h40));
      tick();

      // Reset while in RDWAIT.
      mreq[2][1] = 1'b1;  mwe[2][1] = 1'b0;  maddr[2][1] = 32'h80;
      tick();
      tick();
      check("rst_pre_busy", 2, busy[2], 1'b1);
      apply_reset(1);
      check("rst_busy_now", 2, busy[2], 1'b0);
      n = 0;
      repeat (4) begin
         tick();
         if (m0_ack[2] === 1'b1 || m1_ack[2] === 1'b1) n++;
      end
      check("rst_no_ack", 2, n, 0);
      for (int m = 0; m < 2; m++) begin
         mreq[2][m] = 1'b1;  mwe[2][m] = 1'b1;
         maddr[2][m] = 32'h200 + m;  mwdata[2][m] = 32'h5555_0000 + m;
      end
      tick();
      check("rst_tie_m0", 2, m0_ack[2], 1'b1);
      check("rst_tie_gnt", 2, gnt_id[2], 1'b0);
      tick();
      clear_reqs();
      tick();

      // Random traffic with occasional resets.
      mode = 2;
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(199) == 0) apply_reset(1);
         else tick();
      end
      mode = 0;
      clear_reqs();
      repeat (6) tick();

      $display("%0d/%0d checks passed", npass, nchk);
      $finish;
   end
endmodule
